// File: rtl/clk_trig_encoder.sv
// Multi-channel clock/trigger encoder: NCH frame clocks of DIV fastclk cycles,
// each carrying its channel's trigger state as duty cycle or frame gating.

module clk_trig_lane #(
   parameter int DIV         = 4,
   parameter int HI_IDLE     = 3,
   parameter int HI_TRIG     = 1,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16,
   parameter int PW          = 2
) (
   input  logic             fastclk,
   input  logic             reset,
   input  logic             trigger,
   input  logic             ch_en,
   input  logic             count_clr,
   input  logic             boundary,
   input  logic             mode_nxt,
   input  logic [PW-1:0]    phase_nxt,
   output logic             clk_out,
   output logic             trig_sync,
   output logic [CNT_W-1:0] trig_count
);

   localparam logic [PW-1:0] HI_IDLE_P = PW'(HI_IDLE);
   localparam logic [PW-1:0] HI_TRIG_P = PW'(HI_TRIG);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic                   pending;
   logic                   en_q;
   logic                   en_nxt;
   logic                   trig_nxt;
   logic                   clk_nxt;
   logic [PW-1:0]          hi_lim;

   assign s = sync_q[SYNC_STAGES-1];

   // Controls and trigger bit are latched only at the boundary so a frame is never reshaped mid-way.
   assign en_nxt   = boundary ? ch_en : en_q;
   assign trig_nxt = boundary ? (ch_en & (pending | s)) : trig_sync;
   assign hi_lim   = trig_nxt ? HI_TRIG_P : HI_IDLE_P;

   always_comb begin
      clk_nxt = 1'b0;
      if (en_nxt) begin
         if (mode_nxt) clk_nxt = (phase_nxt < HI_IDLE_P) & ~trig_nxt;
         else          clk_nxt = (phase_nxt < hi_lim);
      end
   end

   always_ff @(posedge fastclk or posedge reset) begin
      if (reset) begin
         sync_q     <= '0;
         pending    <= 1'b0;
         en_q       <= 1'b0;
         trig_sync  <= 1'b0;
         clk_out    <= 1'b0;
         trig_count <= '0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], trigger};
         pending   <= boundary ? 1'b0 : (pending | s);
         en_q      <= en_nxt;
         trig_sync <= trig_nxt;
         clk_out   <= clk_nxt;
         if (count_clr)
            trig_count <= '0;
         else if (boundary && trig_nxt && (trig_count != '1))
            trig_count <= trig_count + CNT_W'(1);
      end
   end

endmodule

module clk_trig_encoder #(
   parameter int NCH         = 4,
   parameter int DIV         = 4,
   parameter int HI_IDLE     = 3,
   parameter int HI_TRIG     = 1,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16
) (
   input  logic                 fastclk,
   input  logic                 reset,
   input  logic [NCH-1:0]       trigger,
   input  logic [NCH-1:0]       ch_en,
   input  logic                 mode,
   input  logic                 count_clr,
   output logic [NCH-1:0]       clk_out,
   output logic [NCH-1:0]       trig_sync,
   output logic                 frame_start,
   output logic [NCH*CNT_W-1:0] trig_count
);

   localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(DIV - 1);

   if (DIV < 2) begin : g_bad_div
      $error("clk_trig_encoder: DIV must be >= 2");
   end
   if (!(HI_TRIG >= 1 && HI_TRIG < HI_IDLE && HI_IDLE <= DIV - 1)) begin : g_bad_hi
      $error("clk_trig_encoder: need 1 <= HI_TRIG < HI_IDLE <= DIV-1");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("clk_trig_encoder: SYNC_STAGES must be >= 2");
   end

   logic [PW-1:0] phase;
   logic [PW-1:0] phase_nxt;
   logic          boundary;
   logic          mode_q;
   logic          mode_nxt;

   // Phase resets to the last slot so the first edge after release opens a frame.
   assign boundary  = (phase == LAST);
   assign phase_nxt = boundary ? '0 : phase + PW'(1);
   assign mode_nxt  = boundary ? mode : mode_q;

   always_ff @(posedge fastclk or posedge reset) begin
      if (reset) begin
         phase       <= LAST;
         mode_q      <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         phase       <= phase_nxt;
         mode_q      <= mode_nxt;
         frame_start <= boundary;
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_lane
      clk_trig_lane #(
         .DIV(DIV), .HI_IDLE(HI_IDLE), .HI_TRIG(HI_TRIG),
         .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W), .PW(PW)
      ) u_lane (
         .fastclk   (fastclk),
         .reset     (reset),
         .trigger   (trigger[i]),
         .ch_en     (ch_en[i]),
         .count_clr (count_clr),
         .boundary  (boundary),
         .mode_nxt  (mode_nxt),
         .phase_nxt (phase_nxt),
         .clk_out   (clk_out[i]),
         .trig_sync (trig_sync[i]),
         .trig_count(trig_count[i*CNT_W +: CNT_W])
      );
   end

endmodule

// File: tb/tb_clk_trig_encoder.sv
// Directed bench for clk_trig_encoder: per-cycle expectations queued as stimulus
// is driven, then popped and checked just after each clock edge.

module tb_clk_trig_encoder;

   localparam int NCH     = 4;
   localparam int DIV     = 4;
   localparam int HI_IDLE = 3;
   localparam int HI_TRIG = 1;
   localparam int SYNC    = 2;
   localparam int CNT_W   = 2;

   logic                 fastclk = 1'b0;
   logic                 reset;
   logic [NCH-1:0]       trigger;
   logic [NCH-1:0]       ch_en;
   logic                 mode;
   logic                 count_clr;
   logic [NCH-1:0]       clk_out;
   logic [NCH-1:0]       trig_sync;
   logic                 frame_start;
   logic [NCH*CNT_W-1:0] trig_count;

   typedef struct {
      logic [NCH-1:0]       clk;
      logic                 fs;
      logic [NCH-1:0]       ts;
      logic [NCH*CNT_W-1:0] cnt;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;
   int   ph    = DIV - 1;
   int   ncyc  = 0;

   clk_trig_encoder #(
      .NCH(NCH), .DIV(DIV), .HI_IDLE(HI_IDLE), .HI_TRIG(HI_TRIG),
      .SYNC_STAGES(SYNC), .CNT_W(CNT_W)
   ) dut (
      .fastclk    (fastclk),
      .reset      (reset),
      .trigger    (trigger),
      .ch_en      (ch_en),
      .mode       (mode),
      .count_clr  (count_clr),
      .clk_out    (clk_out),
      .trig_sync  (trig_sync),
      .frame_start(frame_start),
      .trig_count (trig_count)
   );

   always #5 fastclk = ~fastclk;

   // Frame waveform as the encoding rules define it for slot p.
   function automatic logic [NCH-1:0] wave(input logic [NCH-1:0] en, input logic m,
                                           input logic [NCH-1:0] ts, input int p);
      logic [NCH-1:0] w;
      for (int i = 0; i < NCH; i++) begin
         if (!en[i])   w[i] = 1'b0;
         else if (m)   w[i] = (p < HI_IDLE) && !ts[i];
         else          w[i] = (p < (ts[i] ? HI_TRIG : HI_IDLE));
      end
      return w;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s cyc=%0d got=%h exp=%h", tag, ncyc, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge fastclk);
      #1;
      ncyc++;
   endtask

   // One fastclk cycle: ts and cnt are the values expected after this edge.
   task automatic cyc(input logic [NCH-1:0] en, input logic m, input logic [NCH-1:0] ts,
                      input logic [NCH*CNT_W-1:0] cnt);
      exp_t e;
      int   nph;
      nph   = (ph + 1) % DIV;
      e.clk = wave(en, m, ts, nph);
      e.fs  = (nph == 0);
      e.ts  = ts;
      e.cnt = cnt;
      sbq.push_back(e);
      tick();
      e = sbq.pop_front();
      chk("clk_out",     32'(clk_out),     32'(e.clk));
      chk("frame_start", 32'(frame_start), 32'(e.fs));
      chk("trig_sync",   32'(trig_sync),   32'(e.ts));
      chk("trig_count",  32'(trig_count),  32'(e.cnt));
      ph = nph;
   endtask

   task automatic frame(input logic [NCH-1:0] en, input logic m, input logic [NCH-1:0] ts,
                        input logic [NCH*CNT_W-1:0] cnt);
      for (int k = 0; k < DIV; k++) cyc(en, m, ts, cnt);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_clk"}, 32'(clk_out),     32'h0);
      chk({tag, "_ts"},  32'(trig_sync),   32'h0);
      chk({tag, "_fs"},  32'(frame_start), 32'h0);
      chk({tag, "_cnt"}, 32'(trig_count),  32'h0);
   endtask

   initial begin
      reset = 1'b0; trigger = '0; ch_en = 4'hF; mode = 1'b0; count_clr = 1'b0;
      #1 reset = 1'b1;
      #2 chk_zero("rst_async");
      tick(); tick();
      chk_zero("rst_held");
      reset = 1'b0;
      ph = DIV - 1;

      // idle waveform 1,1,1,0 from the first edge
      frame(4'hF, 1'b0, 4'h0, 8'h00);
      frame(4'hF, 1'b0, 4'h0, 8'h00);

      // held trigger on ch1, counter saturates at 3
      cyc(4'hF, 1'b0, 4'h0, 8'h00);
      trigger = 4'b0010;
      for (int k = 0; k < 3; k++) cyc(4'hF, 1'b0, 4'h0, 8'h00);
      frame(4'hF, 1'b0, 4'b0010, 8'h04);
      frame(4'hF, 1'b0, 4'b0010, 8'h08);
      frame(4'hF, 1'b0, 4'b0010, 8'h0C);
      frame(4'hF, 1'b0, 4'b0010, 8'h0C);

      // clear coincident with an increment wins
      count_clr = 1'b1;
      cyc(4'hF, 1'b0, 4'b0010, 8'h00);
      count_clr = 1'b0;
      for (int k = 0; k < 3; k++) cyc(4'hF, 1'b0, 4'b0010, 8'h00);
      frame(4'hF, 1'b0, 4'b0010, 8'h04);

      // release ch1 just after a boundary: captured level carries one more frame
      cyc(4'hF, 1'b0, 4'b0010, 8'h08);
      trigger = 4'b0000;
      for (int k = 0; k < 3; k++) cyc(4'hF, 1'b0, 4'b0010, 8'h08);
      frame(4'hF, 1'b0, 4'b0010, 8'h0C);
      frame(4'hF, 1'b0, 4'b0000, 8'h0C);

      // single-cycle pulses: ch0 at phase 0 (via pending), ch2 at phase 1
      cyc(4'hF, 1'b0, 4'h0, 8'h0C);
      trigger = 4'b0001;
      cyc(4'hF, 1'b0, 4'h0, 8'h0C);
      trigger = 4'b0100;
      cyc(4'hF, 1'b0, 4'h0, 8'h0C);
      trigger = 4'b0000;
      cyc(4'hF, 1'b0, 4'h0, 8'h0C);
      frame(4'hF, 1'b0, 4'b0101, 8'h1D);
      frame(4'hF, 1'b0, 4'b0000, 8'h1D);

      // gated mode with ch0 held; mode flips back mid-frame
      mode = 1'b1; trigger = 4'b0001;
      frame(4'hF, 1'b1, 4'b0000, 8'h1D);
      for (int k = 0; k < 3; k++) cyc(4'hF, 1'b1, 4'b0001, 8'h1E);
      mode = 1'b0;
      cyc(4'hF, 1'b1, 4'b0001, 8'h1E);

      // ch3 disabled mid-frame, its trigger held: current frame unchanged, then masked
      cyc(4'hF, 1'b0, 4'b0001, 8'h1F);
      cyc(4'hF, 1'b0, 4'b0001, 8'h1F);
      ch_en = 4'b0111; trigger = 4'b1001;
      cyc(4'hF, 1'b0, 4'b0001, 8'h1F);
      cyc(4'hF, 1'b0, 4'b0001, 8'h1F);
      frame(4'b0111, 1'b0, 4'b0001, 8'h1F);
      frame(4'b0111, 1'b0, 4'b0001, 8'h1F);

      // reset mid-frame with triggers held
      cyc(4'b0111, 1'b0, 4'b0001, 8'h1F);
      cyc(4'b0111, 1'b0, 4'b0001, 8'h1F);
      reset = 1'b1;
      #1 chk_zero("rst_mid");
      tick();
      chk_zero("rst_mid_held");
      reset = 1'b0;
      ph = DIV - 1;
      frame(4'b0111, 1'b0, 4'b0000, 8'h00);
      frame(4'b0111, 1'b0, 4'b0001, 8'h01);
      frame(4'b0111, 1'b0, 4'b0001, 8'h02);

      chk("sbq_empty", 32'(sbq.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/clk_trig_encoder.md
Name: clk_trig_encoder

Overview:
- Multi-channel, parametrised clock-and-trigger encoder.
- Derives NCH frame clocks of period DIV fastclk cycles from fastclk. Per frame, each channel encodes its trigger state in the clock waveform, either by duty cycle (mode 0) or by frame gating (mode 1).
- Sits between the board trigger inputs and the SMA clock/trigger fan-out.
- Captures trigger pulses shorter than a frame, and counts encoded triggers per channel.

Parameters:
- NCH, 4, number of channels.
- DIV, 4, frame period in fastclk cycles; must be >= 2.
- HI_IDLE, 3, high cycles per frame when no trigger is encoded.
- HI_TRIG, 1, high cycles per frame when a trigger is encoded; requires 1 <= HI_TRIG < HI_IDLE <= DIV-1, checked at elaboration.
- SYNC_STAGES, 2, trigger synchroniser depth; must be >= 2.
- CNT_W, 16, width of each per-channel trigger counter.

Ports:
- fastclk  in  1  master clock.
- reset  in  1  asynchronous, active-high reset.
- trigger  in  NCH  asynchronous trigger levels, one per channel.
- ch_en  in  NCH  per-channel enable (quasi-static).
- mode  in  1  encoding mode: 0 = duty cycle, 1 = gated (quasi-static).
- count_clr  in  1  synchronous clear of all trigger counters.
- clk_out  out  NCH  encoded frame clock, one per channel, registered.
- trig_sync  out  NCH  trigger bit currently being encoded, one per channel.
- frame_start  out  1  high for the single cycle in which phase == 0.
- trig_count  out  NCH*CNT_W  per-channel encoded-trigger counts; channel i occupies bits [i*CNT_W +: CNT_W].

Behaviour:
- Clock and reset: reset is asynchronous and active-high; all state is clocked on posedge fastclk.
- Reset values:
  - phase = DIV-1.
  - clk_out, trig_sync, frame_start, pending, synchroniser flops = 0.
  - trig_count = 0.
  - mode_q = 0, en_q = 0.
- Phase counter:
  - Counts 0..DIV-1 and wraps.
  - The DIV-1 -> 0 edge is the frame boundary. The first posedge after reset release is a boundary.
- Synchroniser: SYNC_STAGES flops per channel produce the synchronised level s[i].
- Pending capture:
  - pending[i] <= pending[i] | s[i] on every non-boundary edge.
  - Any synchronised high, including a single-cycle one, is therefore retained until the next boundary.
- At each frame boundary:
  - en_q <= ch_en; mode_q <= mode.
  - trig_sync[i] <= en_q_new[i] & (pending[i] | s[i]).
  - pending[i] <= 0.
- Frame-stable controls: mode_q and en_q only change at boundaries. Changes to mode or ch_en mid-frame must never truncate or extend a pulse within the current frame.
- Waveform, per channel, for the frame in which phase = p:
  - Channel disabled (en_q[i] = 0): clk_out[i] = 0 for the whole frame.
  - mode_q = 0: clk_out[i] = 1 iff p < (trig_sync[i] ? HI_TRIG : HI_IDLE).
  - mode_q = 1: clk_out[i] = 1 iff (p < HI_IDLE) and trig_sync[i] = 0. A triggered frame is all zero.
  - clk_out is driven from a flop computed from next-phase values. It is glitch-free and aligned with phase, so clk_out rises on the same edge that phase becomes 0.
- Latency: a trigger level seen by s[i] in frame k is encoded in frame k+1. Worst case from trigger input to encoded frame start is SYNC_STAGES + DIV fastclk cycles.
- frame_start: registered, equals (phase == 0).
- Counters:
  - At each boundary where a channel's new trig_sync[i] = 1, trig_count[i] increments.
  - Counters saturate at 2^CNT_W - 1.
  - count_clr sets all counters to 0; count_clr wins over a simultaneous increment.
- Reset mid-frame: all outputs go to 0 immediately. After release, the block restarts as from power-up and must emit no runt pulse.

Test Plan:
1. DIV=4, HI_IDLE=3, HI_TRIG=1, ch_en=4'hF, mode=0, trigger=0, release reset -> every clk_out[i] repeats 1,1,1,0 starting at the first posedge; frame_start is 1,0,0,0; trig_count all 0.
2. Hold trigger[1]=1 -> within 2 frames, clk_out[1] repeats 1,0,0,0 and trig_sync[1]=1. Other channels stay 1,1,1,0. trig_count[1] increments by 1 per frame.
3. Single-fastclk-cycle pulse on trigger[2] at phase 1 -> exactly one frame of 1,0,0,0 on clk_out[2], in frame k+1 or k+2. trig_count[2] = 1.
4. mode=1 with trigger[0] held high -> clk_out[0] = 0,0,0,0 per frame. Toggle mode at phase 2 -> the current frame completes unchanged and the new mode applies from the next boundary.
5. Deassert ch_en[3] at phase 1 -> the current frame completes, then clk_out[3]=0 and trig_sync[3]=0 with no count. With CNT_W=2 and trigger held, trig_count saturates at 3. count_clr in the same cycle as an increment -> 0.
6. Assert reset at phase 1 with trigger held -> clk_out and trig_sync go to 0 asynchronously. After release, the waveform resumes as in test 1, or test 2 after synchroniser latency, with trig_count restarted from 0.
